// File: rtl/hbnlstrip_pkg.sv
// rtl/hbnlstrip_pkg.sv - shared character constants, states and byte classes for hbnlstrip
package hbnlstrip_pkg;

   localparam logic [6:0] HB_CR   = 7'h0d;
   localparam logic [6:0] HB_LF   = 7'h0a;
   localparam logic [6:0] HB_SP   = 7'h20;
   localparam logic [6:0] HB_TAB  = 7'h09;
   localparam logic [6:0] HB_IDLE = 7'h7f;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LINE    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      C_TERM  = 2'd0,
      C_WS    = 2'd1,
      C_CTRL  = 2'd2,
      C_PRINT = 2'd3
   } bclass_t;

endpackage

// File: rtl/hbnlstrip.sv
// rtl/hbnlstrip.sv - receive-side line normaliser ahead of the hexbus hex decoder
// Drops blank lines and control bytes, collapses whitespace, ends every line with one CR.
module hbnlstrip
   import hbnlstrip_pkg::*;
#(
   parameter int LGMAXLINE = 7
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_stb,
   input  logic [6:0] i_byte,
   output logic       o_busy,
   output logic       o_stb,
   output logic [6:0] o_byte,
   input  logic       i_busy,
   output logic       o_overflow
);

   localparam logic [LGMAXLINE-1:0] MAXLINE  = '1;
   localparam logic [LGMAXLINE-1:0] COUNT_ONE = {{(LGMAXLINE-1){1'b0}}, 1'b1};

   function automatic bclass_t classify(input logic [6:0] c);
      if (c == HB_CR || c == HB_LF)
         return C_TERM;
      else if (c == HB_SP || c == HB_TAB)
         return C_WS;
      else if (c < 7'h20 || c == HB_IDLE)
         return C_CTRL;
      else
         return C_PRINT;
   endfunction

   state_t               state_q, state_d;
   logic [LGMAXLINE-1:0] count_q, count_d;
   logic                 last_sp_q, last_sp_d;
   logic                 stb_q, stb_d;
   logic [6:0]           byte_q, byte_d;
   logic                 overflow_q, overflow_d;
   logic                 accept;
   bclass_t              cls;

   assign o_busy     = stb_q && i_busy;
   assign accept     = i_stb && !o_busy;
   assign cls        = classify(i_byte);
   assign o_stb      = stb_q;
   assign o_byte     = byte_q;
   assign o_overflow = overflow_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      last_sp_d  = last_sp_q;
      overflow_d = 1'b0;
      // A stalled output register holds; a free one empties unless refilled below.
      if (o_busy) begin
         stb_d  = stb_q;
         byte_d = byte_q;
      end else begin
         stb_d  = 1'b0;
         byte_d = HB_IDLE;
      end

      if (accept && cls != C_CTRL) begin
         case (state_q)
            S_IDLE: begin
               if (cls == C_PRINT) begin
                  stb_d     = 1'b1;
                  byte_d    = i_byte;
                  count_d   = COUNT_ONE;
                  last_sp_d = 1'b0;
                  state_d   = S_LINE;
               end
            end
            S_LINE: begin
               if (cls == C_TERM) begin
                  stb_d     = 1'b1;
                  byte_d    = HB_CR;
                  count_d   = '0;
                  last_sp_d = 1'b0;
                  state_d   = S_IDLE;
               end else if (cls == C_PRINT) begin
                  if (count_q < MAXLINE) begin
                     stb_d     = 1'b1;
                     byte_d    = i_byte;
                     count_d   = count_q + COUNT_ONE;
                     last_sp_d = 1'b0;
                  end else begin
                     overflow_d = 1'b1;
                     state_d    = S_DISCARD;
                  end
               end else if (!last_sp_q && count_q < MAXLINE) begin
                  stb_d     = 1'b1;
                  byte_d    = HB_SP;
                  count_d   = count_q + COUNT_ONE;
                  last_sp_d = 1'b1;
               end
            end
            S_DISCARD: begin
               // The CR makes the decoder abandon the truncated command.
               if (cls == C_TERM) begin
                  stb_d     = 1'b1;
                  byte_d    = HB_CR;
                  count_d   = '0;
                  last_sp_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         last_sp_q  <= 1'b0;
         stb_q      <= 1'b0;
         byte_q     <= HB_IDLE;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         last_sp_q  <= last_sp_d;
         stb_q      <= stb_d;
         byte_q     <= byte_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
